tlb_maint_ctrl: RTL

- Sequences TLB maintenance operations (TLBWR, TLBFILL, INVTLB) committed at writeback onto the TLB's single write port and a dedicated scan read port.
- Sits between the writeback stage and the TLB array.
- Generates the TLBFILL victim index.
- Walks all entries for INVTLB, issuing one conditional clear per cycle.
- Holds off further requests (pipeline stall) while busy.

---
 rtl/tlb_maint_ctrl_pkg.sv | 51 +++++
 rtl/tlb_maint_ctrl_if.sv | 46 ++++
 rtl/tlb_fill_idx_gen.sv | 39 +++
 rtl/tlb_maint_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/tlb_maint_ctrl_pkg.sv
// Shared definitions for the TLB maintenance controller: op codes, INVTLB opcodes,
// packed-entry field offsets and FSM states.
package tlb_maint_ctrl_pkg;

  typedef enum logic [1:0] {
    OpTlbwr   = 2'd0,
    OpTlbfill = 2'd1,
    OpInvtlb  = 2'd2,
    OpRsvd    = 2'd3
  } tlb_op_e;

  localparam logic [4:0] InvAll0      = 5'd0;
  localparam logic [4:0] InvAll1      = 5'd1;
  localparam logic [4:0] InvG         = 5'd2;
  localparam logic [4:0] InvNg        = 5'd3;
  localparam logic [4:0] InvNgAsid    = 5'd4;
  localparam logic [4:0] InvNgAsidVa  = 5'd5;
  localparam logic [4:0] InvGOrAsidVa = 5'd6;

  // Packed entry {e,vppn,ps,asid,g,ppn0,plv0,mat0,d0,v0,ppn1,plv1,mat1,d1,v1}, LSB offsets.
  localparam int unsigned TlbeW    = 89;
  localparam int unsigned OffV1    = 0;
  localparam int unsigned OffD1    = 1;
  localparam int unsigned OffMat1  = 2;
  localparam int unsigned OffPlv1  = 4;
  localparam int unsigned OffPpn1  = 6;
  localparam int unsigned OffV0    = 26;
  localparam int unsigned OffD0    = 27;
  localparam int unsigned OffMat0  = 28;
  localparam int unsigned OffPlv0  = 30;
  localparam int unsigned OffPpn0  = 32;
  localparam int unsigned OffG     = 52;
  localparam int unsigned OffAsid  = 53;
  localparam int unsigned OffPs    = 63;
  localparam int unsigned OffVppn  = 69;
  localparam int unsigned OffE     = 88;

  // Page size that compares only the upper vppn bits.
  localparam logic [5:0] HugePs = 6'd21;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StScan  = 2'd2
  } state_e;

  function automatic logic inv_op_legal(input logic [4:0] inv_op);
    return inv_op <= InvGOrAsidVa;
  endfunction

endpackage

// File: rtl/tlb_maint_ctrl_if.sv
// Request, scan-read and write-port bundle between writeback, controller and TLB array.
// master: writeback + TLB array side; slave: the maintenance controller.
interface tlb_maint_ctrl_if #(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned ASID_W = 10,
  parameter int unsigned VPPN_W = 19,
  parameter int unsigned TLBE_W = 89
);
  localparam int unsigned IDX_W = $clog2(TLBNUM);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [IDX_W-1:0]  req_index;
  logic [TLBE_W-1:0] req_entry;
  logic [4:0]        req_inv_op;
  logic [ASID_W-1:0] req_asid;
  logic [VPPN_W-1:0] req_vppn;

  logic [IDX_W-1:0]  rd_index;
  logic              rd_e;
  logic              rd_g;
  logic [5:0]        rd_ps;
  logic [ASID_W-1:0] rd_asid;
  logic [VPPN_W-1:0] rd_vppn;

  logic              we;
  logic [IDX_W-1:0]  w_index;
  logic [TLBE_W-1:0] w_entry;
  logic              busy;
  logic              done;
  logic              inv_err;

  modport master (
    output req_valid, req_op, req_index, req_entry, req_inv_op, req_asid, req_vppn,
    output rd_e, rd_g, rd_ps, rd_asid, rd_vppn,
    input  req_ready, rd_index, we, w_index, w_entry, busy, done, inv_err
  );

  modport slave (
    input  req_valid, req_op, req_index, req_entry, req_inv_op, req_asid, req_vppn,
    input  rd_e, rd_g, rd_ps, rd_asid, rd_vppn,
    output req_ready, rd_index, we, w_index, w_entry, busy, done, inv_err
  );

endinterface

// File: rtl/tlb_fill_idx_gen.sv
// TLBFILL victim index source: round-robin counter by default, or an 8-bit LFSR
// free-running every cycle when TLBFILL_RANDOM_EN is defined.
module tlb_fill_idx_gen #(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fill_acc,
  output logic [IDX_W-1:0] fill_idx
);

`ifdef TLBFILL_RANDOM_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       unused_fill_acc;

  assign unused_fill_acc = fill_acc;
  // Fibonacci x^8+x^6+x^5+x^4+1.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk) begin
    if (!rstn) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end

  assign fill_idx = lfsr_q[IDX_W-1:0];
`else
  logic [IDX_W-1:0] rr_q, rr_d;

  assign rr_d = fill_acc ? rr_q + 1'b1 : rr_q;

  always_ff @(posedge clk) begin
    if (!rstn) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  assign fill_idx = rr_q;
`endif

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: TLBWR/TLBFILL as single writes, INVTLB as a full-table scan
// with one conditional clear per cycle. Fill policy selected by TLBFILL_RANDOM_EN.
module tlb_maint_ctrl
  import tlb_maint_ctrl_pkg::*;
#(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned ASID_W = 10,
  parameter int unsigned VPPN_W = 19,
  parameter int unsigned TLBE_W = 89
) (
  input logic            clk,
  input logic            rstn,
  tlb_maint_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(TLBNUM);
  localparam logic [IDX_W-1:0] CntLast = IDX_W'(TLBNUM - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TLBE_W-1:0] entry_q, entry_d;
  logic [4:0]        inv_op_q, inv_op_d;
  logic [ASID_W-1:0] asid_q, asid_d;
  logic [VPPN_W-1:0] vppn_q, vppn_d;
  logic              inv_err_q, inv_err_d;
  logic              rsv_done_q, rsv_done_d;

  tlb_op_e           op;
  logic              fill_acc;
  logic [IDX_W-1:0]  fill_idx;
  logic              va_match, asid_eq, op_match, scan_match;

  assign op       = tlb_op_e'(bus.req_op);
  assign fill_acc = bus.req_valid && (state_q == StIdle) && (op == OpTlbfill);

  tlb_fill_idx_gen #(
    .IDX_W (IDX_W)
  ) u_fill_idx_gen (
    .clk      (clk),
    .rstn     (rstn),
    .fill_acc (fill_acc),
    .fill_idx (fill_idx)
  );

  // Huge pages ignore the low 9 vppn bits.
  assign va_match = (bus.rd_ps == HugePs) ? (bus.rd_vppn[VPPN_W-1:9] == vppn_q[VPPN_W-1:9])
                                          : (bus.rd_vppn == vppn_q);
  assign asid_eq  = (bus.rd_asid == asid_q);

  always_comb begin
    op_match = 1'b0;
    case (inv_op_q)
      InvAll0, InvAll1: op_match = 1'b1;
      InvG:             op_match = bus.rd_g;
      InvNg:            op_match = !bus.rd_g;
      InvNgAsid:        op_match = !bus.rd_g && asid_eq;
      InvNgAsidVa:      op_match = !bus.rd_g && asid_eq && va_match;
      InvGOrAsidVa:     op_match = (bus.rd_g || asid_eq) && va_match;
      default:          op_match = 1'b0;
    endcase
  end

  assign scan_match = bus.rd_e && op_match;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    entry_d     = entry_q;
    inv_op_d    = inv_op_q;
    asid_d      = asid_q;
    vppn_d      = vppn_q;
    inv_err_d   = 1'b0;
    rsv_done_d  = 1'b0;

    bus.req_ready = 1'b0;
    bus.we        = 1'b0;
    bus.w_index   = '0;
    bus.w_entry   = '0;
    bus.busy      = 1'b0;
    bus.done      = rsv_done_q;
    bus.inv_err   = inv_err_q;
    bus.rd_index  = cnt_q;

    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          unique case (op)
            OpTlbwr, OpTlbfill: begin
              entry_d = bus.req_entry;
              idx_d   = (op == OpTlbfill) ? fill_idx : bus.req_index;
              state_d = StWrite;
            end
            OpInvtlb: begin
              if (inv_op_legal(bus.req_inv_op)) begin
                inv_op_d = bus.req_inv_op;
                asid_d   = bus.req_asid;
                vppn_d   = bus.req_vppn;
                cnt_d    = '0;
                state_d  = StScan;
              end else begin
                inv_err_d = 1'b1;
              end
            end
            OpRsvd: rsv_done_d = 1'b1;
          endcase
        end
      end
      StWrite: begin
        bus.busy    = 1'b1;
        bus.we      = 1'b1;
        bus.w_index = idx_q;
        bus.w_entry = entry_q;
        bus.done    = 1'b1;
        state_d     = StIdle;
      end
      StScan: begin
        bus.busy    = 1'b1;
        bus.we      = scan_match;
        bus.w_index = cnt_q;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          bus.done = 1'b1;
          cnt_d    = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      entry_q    <= '0;
      inv_op_q   <= '0;
      asid_q     <= '0;
      vppn_q     <= '0;
      inv_err_q  <= 1'b0;
      rsv_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      entry_q    <= entry_d;
      inv_op_q   <= inv_op_d;
      asid_q     <= asid_d;
      vppn_q     <= vppn_d;
      inv_err_q  <= inv_err_d;
      rsv_done_q <= rsv_done_d;
    end
  end

endmodule
